// File: rtl/key_debounce.sv
// key_debounce: synchronises, debounces and classifies the active-low DE2
// pushbuttons. Each key has its own synchroniser, FSM and counter, and emits
// a registered debounced level plus one-cycle press, release and long-press
// strobes.
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic              CLOCK_50,
  input  logic              RST_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  // One counter serves both the debounce window and the long-press timer,
  // so it is sized for the larger of the two.
  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int W          = $clog2(MAX_CYCLES) + 1;

  localparam logic [W-1:0] DEB_LAST  = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] LONG_LAST = W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } state_t;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    logic           sync1_reg, sync2_reg;
    logic           pressed;
    state_t         state_reg, state_next;
    logic [W-1:0]   cnt_reg, cnt_next;
    logic           long_done_reg, long_done_next;
    logic           level_reg, level_next;
    logic           press_reg, press_next;
    logic           release_reg, release_next;
    logic           long_reg, long_next;

    // Two-flop synchroniser; resets to the released level (KEY high).
    always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
        sync1_reg <= 1'b1;
        sync2_reg <= 1'b1;
      end else begin
        sync1_reg <= KEY[gi];
        sync2_reg <= sync1_reg;
      end
    end

    // Active-high view of the synchronised key.
    assign pressed = ~sync2_reg;

    // State, counter, flag and output registers.
    always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
        state_reg     <= IDLE;
        cnt_reg       <= '0;
        long_done_reg <= 1'b0;
        level_reg     <= 1'b0;
        press_reg     <= 1'b0;
        release_reg   <= 1'b0;
        long_reg      <= 1'b0;
      end else begin
        state_reg     <= state_next;
        cnt_reg       <= cnt_next;
        long_done_reg <= long_done_next;
        level_reg     <= level_next;
        press_reg     <= press_next;
        release_reg   <= release_next;
        long_reg      <= long_next;
      end
    end

    // Next-state logic; strobes are computed here so they leave registered.
    always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      long_done_next = long_done_reg;
      level_next     = level_reg;
      press_next     = 1'b0;
      release_next   = 1'b0;
      long_next      = 1'b0;
      case (state_reg)
        IDLE: begin
          if (pressed) begin
            state_next = PRESS_CHK;
            cnt_next   = '0;
          end
        end
        PRESS_CHK: begin
          if (!pressed) begin
            state_next = IDLE;
          end else if (cnt_reg == DEB_LAST) begin
            state_next = PRESSED;
            cnt_next   = '0;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + W'(1);
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state_next = RELEASE_CHK;
            cnt_next   = '0;
          end else if (!long_done_reg && (cnt_reg == LONG_LAST)) begin
            long_next      = 1'b1;
            long_done_next = 1'b1;
          end else if (cnt_reg != '1) begin
            cnt_next = cnt_reg + W'(1);
          end
        end
        RELEASE_CHK: begin
          // A bounce back to pressed restarts the hold timer but keeps
          // long_done, so a glitchy hold cannot fire a second long strobe.
          if (pressed) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_next     = IDLE;
            level_next     = 1'b0;
            release_next   = 1'b1;
            long_done_next = 1'b0;
          end else begin
            cnt_next = cnt_reg + W'(1);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    assign key_level[gi]   = level_reg;
    assign key_press[gi]   = press_reg;
    assign key_release[gi] = release_reg;
    assign key_long[gi]    = long_reg;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed vectors for key_debounce with DEBOUNCE_CYCLES=4
// and LONG_CYCLES=16. Edge t is the rising edge that samples the KEY value
// set for step t; outputs are sampled 1 ns after that edge.
module tb_key_debounce;
  localparam int N_KEYS = 4;
  localparam int DEB    = 4;
  localparam int LONG   = 16;

  logic              CLOCK_50 = 1'b0;
  logic              RST_N    = 1'b0;
  logic [N_KEYS-1:0] KEY      = '1;
  logic [N_KEYS-1:0] key_level, key_press, key_release, key_long;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .N_KEYS          (N_KEYS),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RST_N       (RST_N),
    .KEY         (KEY),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // One scenario: keys in mask held low over [low_start, low_end) except for
  // a high glitch of glitch_len steps at glitch_start; expected event edges.
  typedef struct {
    logic [3:0] mask;
    int         low_start;
    int         low_end;
    int         glitch_start;
    int         glitch_len;
    int         exp_press;
    int         exp_long;
    int         exp_release;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check4(input string name, input int t,
                        input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %b, expected %b", name, t, act, exp);
    end
  endtask

  task automatic check_all(input int t, input logic [3:0] e_level,
                           input logic [3:0] e_press, input logic [3:0] e_rel,
                           input logic [3:0] e_long);
    check4("key_level", t, key_level, e_level);
    check4("key_press", t, key_press, e_press);
    check4("key_release", t, key_release, e_rel);
    check4("key_long", t, key_long, e_long);
  endtask

  initial begin
    int err0;
    logic [3:0] lv;

    // Clean press/release of KEY[0]: press at 16, release at 36, no long.
    vecs[0] = '{mask: 4'b0001, low_start: 10, low_end: 30, glitch_start: -1, glitch_len: 0,
                exp_press: 16, exp_long: -1, exp_release: 36};
    // Long press of KEY[2]: press 6, long 22, release 46.
    vecs[1] = '{mask: 4'b0100, low_start: 0, low_end: 40, glitch_start: -1, glitch_len: 0,
                exp_press: 6, exp_long: 22, exp_release: 46};
    // Release glitch on KEY[3] before the long timer expires.
    vecs[2] = '{mask: 4'b1000, low_start: 0, low_end: 30, glitch_start: 12, glitch_len: 2,
                exp_press: 6, exp_long: -1, exp_release: 36};
    // Glitch after key_long: timer restarts but no second long strobe.
    vecs[3] = '{mask: 4'b1000, low_start: 0, low_end: 50, glitch_start: 25, glitch_len: 2,
                exp_press: 6, exp_long: 22, exp_release: 56};
    // KEY[0] and KEY[3] together: strobes reported in the same cycle.
    vecs[4] = '{mask: 4'b1001, low_start: 0, low_end: 10, glitch_start: -1, glitch_len: 0,
                exp_press: 6, exp_long: -1, exp_release: 16};

    // Reset with all keys held: outputs stay 0, then all four press at edge 6.
    err0  = errors;
    RST_N = 1'b0;
    KEY   = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all(-3 + i, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    RST_N = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      KEY = (t < 11) ? 4'b0000 : 4'b1111;
      tick();
      check_all(t, (t >= 6 && t < 17) ? 4'b1111 : 4'b0000,
                (t == 6) ? 4'b1111 : 4'b0000,
                (t == 17) ? 4'b1111 : 4'b0000, 4'b0000);
    end
    $display("scenario reset_all_held: errors %0d", errors - err0);

    // Reset while KEY[0] is held: no release, fresh press 6 edges after reset.
    err0 = errors;
    for (int t = 0; t <= 35; t++) begin
      KEY   = (t < 26) ? 4'b1110 : 4'b1111;
      RST_N = (t == 12 || t == 13) ? 1'b0 : 1'b1;
      tick();
      lv = ((t >= 6 && t < 12) || (t >= 20 && t < 32)) ? 4'b0001 : 4'b0000;
      check_all(t, lv, (t == 6 || t == 20) ? 4'b0001 : 4'b0000,
                (t == 32) ? 4'b0001 : 4'b0000, 4'b0000);
    end
    $display("scenario reset_mid_press: errors %0d", errors - err0);

    // Bounce on KEY[1]: 2-sample runs never reach acceptance.
    err0 = errors;
    for (int t = 0; t < 30; t++) begin
      KEY = 4'b1111;
      if (t < 20 && ((t / 2) % 2 == 0)) KEY[1] = 1'b0;
      tick();
      check_all(t, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    $display("scenario bounce_key1: errors %0d", errors - err0);

    // Table-driven scenarios.
    for (int v = 0; v < 5; v++) begin
      err0 = errors;
      for (int t = 0; t <= vecs[v].exp_release + 4; t++) begin
        logic low;
        low = (t >= vecs[v].low_start) && (t < vecs[v].low_end);
        if (vecs[v].glitch_start >= 0 && t >= vecs[v].glitch_start &&
            t < vecs[v].glitch_start + vecs[v].glitch_len)
          low = 1'b0;
        KEY = low ? ~vecs[v].mask : 4'b1111;
        tick();
        check_all(t,
                  (t >= vecs[v].exp_press && t < vecs[v].exp_release) ? vecs[v].mask : 4'b0000,
                  (t == vecs[v].exp_press) ? vecs[v].mask : 4'b0000,
                  (t == vecs[v].exp_release) ? vecs[v].mask : 4'b0000,
                  (t == vecs[v].exp_long) ? vecs[v].mask : 4'b0000);
      end
      $display("scenario vector %0d mask %b: errors %0d", v, vecs[v].mask, errors - err0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioning stage for the DE2 pushbuttons: synchronises the raw active-low `KEY` inputs to `CLOCK_50`, debounces each key independently and emits clean level, press, release and long-press events. Sits directly upstream of the LED blink/counter logic, which consumes `key_press`/`key_long` as single-cycle strobes (e.g. toggle enable, change rate) instead of sampling raw switches.

## Interface
- `N_KEYS`, 4: number of independent keys handled.
- `DEBOUNCE_CYCLES`, 1000000: cycles a new level must stay stable before acceptance (20 ms at 50 MHz); legal range ≥ 2.
- `LONG_CYCLES`, 50000000: cycles of accepted press before `key_long` fires (1 s at 50 MHz); legal range ≥ 1.
- Counter width W = clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)) + 1; one W-bit counter per key.

- `CLOCK_50`  in  1  system clock, 50 MHz; single clock domain.
- `RST_N`  in  1  reset, synchronous, active-low.
- `KEY`  in  N_KEYS  raw pushbuttons, active-low (0 = pressed), asynchronous to `CLOCK_50`.
- `key_level`  out  N_KEYS  debounced state, active-high (1 = pressed).
- `key_press`  out  N_KEYS  one-cycle strobe on accepted press.
- `key_release`  out  N_KEYS  one-cycle strobe on accepted release.
- `key_long`  out  N_KEYS  one-cycle strobe, at most once per press, after LONG_CYCLES held.

## Operation
- Per key: 2-flop synchroniser on `KEY[i]`, inverted to `p` (1 = pressed). Synchroniser flops reset to 1 (released).
- Per-key FSM, states IDLE, PRESS_CHK, PRESSED, RELEASE_CHK; per-key counter `cnt`, flag `long_done`.
- IDLE: `p`=1 → PRESS_CHK, cnt←0. Else stay.
- PRESS_CHK: `p`=0 → IDLE (bounce rejected, no event). `p`=1 and cnt = DEBOUNCE_CYCLES−1 → PRESSED, cnt←0, `key_level`←1, `key_press` pulse. Otherwise cnt←cnt+1.
- PRESSED: `p`=0 → RELEASE_CHK, cnt←0. Else if !`long_done` and cnt = LONG_CYCLES−1 → `key_long` pulse, `long_done`←1. Else cnt←cnt+1, saturating at all-ones.
- RELEASE_CHK: `p`=1 → PRESSED, cnt←0 (long timer restarts; `long_done` retained, so no second `key_long`). `p`=0 and cnt = DEBOUNCE_CYCLES−1 → IDLE, `key_level`←0, `key_release` pulse, `long_done`←0. Otherwise cnt←cnt+1.
- `key_level` stays 1 throughout RELEASE_CHK; glitches never produce events.
- Keys fully independent; simultaneous events on several keys all reported in the same cycle.
- `key_press` and `key_release` of one key never assert in the same cycle; `key_long` never coincides with `key_press`.

## Timing
- All outputs registered; no combinational path from `KEY` to any output.
- Reset (`RST_N`=0 at a rising edge): all FSMs IDLE, counters 0, `long_done` 0, synchronisers 1, all outputs 0 from the next cycle. Takes precedence over all transitions.
- Press latency: `KEY[i]` held low from sampling edge k → `key_press[i]` and `key_level[i]` high after edge k+DEBOUNCE_CYCLES+2; pulse lasts exactly one cycle.
- Release latency: symmetric, `key_release[i]` high after edge k+DEBOUNCE_CYCLES+2 where k is the first edge sampling `KEY[i]`=1.
- Long press: `key_long[i]` high LONG_CYCLES cycles after the cycle `key_press[i]` was high (uninterrupted hold).
- Bounce: any pressed run shorter than DEBOUNCE_CYCLES+1 samples yields no event.
- Reset mid-press with key still held: no `key_release`; fresh `key_press` DEBOUNCE_CYCLES+2 edges after `RST_N` returns high.

## Test plan
(bench parameters: N_KEYS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
- Reset: `RST_N`=0 for 3 cycles with `KEY`=4'b0000 → all outputs 0 during reset; `key_press`=4'b1111 exactly 6 edges after release of reset.
- Clean press/release of KEY[0]: drive 0 at edge 10, 1 at edge 30 → `key_press[0]` after edge 16 only, `key_level[0]` high edges 16–35, `key_release[0]` after edge 36 only; no `key_long`.
- Bounce: KEY[1] toggles 0/1 every 2 cycles for 20 cycles, then stays 1 → no event on any output.
- Long press: KEY[2] low from edge 0 for 40 cycles → `key_press[2]` after edge 6, `key_long[2]` after edge 22 exactly once, `key_release[2]` after edge 46.
- Release glitch: KEY[3] held low 30 cycles with a 2-cycle high glitch at cycle 12 → one `key_press`, `key_level[3]` continuous, one release; no second `key_long`.
- Concurrency: KEY[0] and KEY[3] pressed on the same edge → `key_press`=4'b1001 in a single cycle.
